// File: rtl/fpu_classify_unit_mp.sv
// FCLASS unit for H/S/D operands in the FPU EX stage.
// The classification happens in stage 1. Stages 2..LATENCY are plain delay stages.
// The result is held in DONE until the consumer takes it (ready/valid).
// Improperly NaN-boxed narrow operands classify as canonical qNaN.
module fpu_classify_unit_mp #(
  parameter int unsigned FLEN     = 64,
  parameter bit          ENABLE_H = 1'b1,
  parameter int unsigned LATENCY  = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_use_unit,
  input  logic [1:0]      i_fmt,
  input  logic [FLEN-1:0] i_operand,
  input  logic [4:0]      i_dest_reg,
  input  logic            i_flush,
  input  logic            i_result_ready,
  output logic [31:0]     o_result,
  output logic            o_valid,
  output logic            o_busy,
  output logic [4:0]      o_dest_reg,
  output logic            o_start
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] FmtS = 2'b00;
  localparam logic [1:0] FmtD = 2'b01;
  localparam logic [1:0] FmtH = 2'b10;

  // Number of cycles spent in RUN between the start edge and entry into DONE.
  localparam logic [2:0] RunCycles = 3'(LATENCY - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [9:0] stg_q [LATENCY];
  logic [4:0] dest_q;

  logic [63:0] op64;
  logic        fmt_ok;
  logic        can_start;
  logic        start;

  logic        sign;
  logic        exp_ones;
  logic        exp_zero;
  logic        man_zero;
  logic        man_msb;
  logic        boxed;
  logic [9:0]  mask;

  // The operand is widened to 64 bits so field selects stay in range for both FLEN values.
  assign op64 = 64'(i_operand);

  // Determine whether the format is accepted and whether a request starts this cycle.
  always_comb begin
    fmt_ok = 1'b1;
    if (i_fmt == 2'b11) fmt_ok = 1'b0;
    if ((i_fmt == FmtH) && !ENABLE_H) fmt_ok = 1'b0;
    if ((i_fmt == FmtD) && (FLEN == 32)) fmt_ok = 1'b0;
  end

  assign can_start = ((state_q == StIdle) || ((state_q == StDone) && i_result_ready)) &&
                     !i_flush && !i_rst;
  assign start     = i_valid && i_use_unit && fmt_ok && can_start;
  assign o_start   = start;

  // Extract the sign and exponent/mantissa properties of the selected format, plus NaN-boxing.
  always_comb begin
    sign     = 1'b0;
    exp_ones = 1'b0;
    exp_zero = 1'b0;
    man_zero = 1'b0;
    man_msb  = 1'b0;
    boxed    = 1'b1;
    case (i_fmt)
      FmtS: begin
        sign     = op64[31];
        exp_ones = &op64[30:23];
        exp_zero = ~|op64[30:23];
        man_zero = ~|op64[22:0];
        man_msb  = op64[22];
        boxed    = (FLEN == 32) || (&op64[63:32]);
      end
      FmtD: begin
        sign     = op64[63];
        exp_ones = &op64[62:52];
        exp_zero = ~|op64[62:52];
        man_zero = ~|op64[51:0];
        man_msb  = op64[51];
      end
      FmtH: begin
        sign     = op64[15];
        exp_ones = &op64[14:10];
        exp_zero = ~|op64[14:10];
        man_zero = ~|op64[9:0];
        man_msb  = op64[9];
        boxed    = (FLEN == 32) ? (&op64[31:16]) : (&op64[63:16]);
      end
      default: ;
    endcase
  end

  // Build the one-hot class mask from the extracted properties.
  always_comb begin
    mask = '0;
    if (!boxed) begin
      mask[9] = 1'b1;
    end else if (exp_ones) begin
      if (man_zero) begin
        if (sign) mask[0] = 1'b1;
        else      mask[7] = 1'b1;
      end else if (man_msb) begin
        mask[9] = 1'b1;
      end else begin
        mask[8] = 1'b1;
      end
    end else if (exp_zero) begin
      if (man_zero) begin
        if (sign) mask[3] = 1'b1;
        else      mask[4] = 1'b1;
      end else begin
        if (sign) mask[2] = 1'b1;
        else      mask[5] = 1'b1;
      end
    end else begin
      if (sign) mask[1] = 1'b1;
      else      mask[6] = 1'b1;
    end
  end

  // Next-state logic. A flush overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = RunCycles;
          if (LATENCY == 1) state_d = StDone;
          else              state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q <= 3'd1) state_d = StDone;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StDone: begin
        if (i_result_ready) begin
          if (start) begin
            cnt_d = RunCycles;
            if (LATENCY == 1) state_d = StDone;
            else              state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (i_flush) state_d = StIdle;
  end

  // Update the state and counter, capture on start, and advance the delay stages while running.
  // The last stage only changes on the edge that enters DONE, so o_result
  // holds its previous value whenever o_valid is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dest_q  <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) stg_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        stg_q[0] <= mask;
        dest_q   <= i_dest_reg;
      end
      if ((state_q == StRun) && !i_flush) begin
        for (int unsigned k = 1; k < LATENCY; k++) stg_q[k] <= stg_q[k-1];
      end
    end
  end

  assign o_result   = {22'b0, stg_q[LATENCY-1]};
  assign o_valid    = (state_q == StDone);
  assign o_busy     = (state_q != StIdle);
  assign o_dest_reg = dest_q;

endmodule

// File: tb/tb_fpu_classify_unit_mp.sv
// Bench for fpu_classify_unit_mp: instance A uses the default parameters,
// and instance B uses FLEN=32, ENABLE_H=0 and LATENCY=1.
module tb_fpu_classify_unit_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst;
  logic        valid, use_unit, flush, ready;
  logic [1:0]  fmt;
  logic [63:0] operand;
  logic [4:0]  dest;
  logic [31:0] result;
  logic        ovalid, busy, ostart;
  logic [4:0]  odest;

  logic        b_valid, b_use, b_flush, b_ready;
  logic [1:0]  b_fmt;
  logic [31:0] b_operand;
  logic [4:0]  b_dest;
  logic [31:0] b_result;
  logic        b_ovalid, b_busy, b_ostart;
  logic [4:0]  b_odest;

  fpu_classify_unit_mp #(.FLEN(64), .ENABLE_H(1'b1), .LATENCY(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_use_unit(use_unit), .i_fmt(fmt),
    .i_operand(operand), .i_dest_reg(dest), .i_flush(flush), .i_result_ready(ready),
    .o_result(result), .o_valid(ovalid), .o_busy(busy), .o_dest_reg(odest), .o_start(ostart)
  );

  fpu_classify_unit_mp #(.FLEN(32), .ENABLE_H(1'b0), .LATENCY(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_use_unit(b_use), .i_fmt(b_fmt),
    .i_operand(b_operand), .i_dest_reg(b_dest), .i_flush(b_flush), .i_result_ready(b_ready),
    .o_result(b_result), .o_valid(b_ovalid), .o_busy(b_busy), .o_dest_reg(b_odest),
    .o_start(b_ostart)
  );

  function automatic int exp_bits(input logic [1:0] f);
    return (f == 2'b00) ? 8 : (f == 2'b01) ? 11 : 5;
  endfunction

  function automatic int man_bits(input logic [1:0] f);
    return (f == 2'b00) ? 23 : (f == 2'b01) ? 52 : 10;
  endfunction

  // Reference classification: unpack the fields arithmetically and apply the FCLASS rules.
  function automatic logic [31:0] ref_class(input logic [1:0] f, input logic [63:0] op,
                                            input int flen);
    int eb, mb, w, bitn;
    logic [63:0] e, m, emax;
    logic s;
    eb = exp_bits(f);
    mb = man_bits(f);
    w  = 1 + eb + mb;
    for (int i = w; i < flen; i++) if (!op[i]) return 32'h200;
    s    = op[w-1];
    emax = (64'd1 << eb) - 1;
    e    = (op >> mb) & emax;
    m    = op & ((64'd1 << mb) - 1);
    if (e == emax) begin
      if (m == 0)        bitn = s ? 0 : 7;
      else if (m[mb-1])  bitn = 9;
      else               bitn = 8;
    end else if (e == 0) begin
      bitn = (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    end else begin
      bitn = s ? 1 : 6;
    end
    return 32'd1 << bitn;
  endfunction

  function automatic logic fmt_ok_ref(input logic [1:0] f, input logic en_h, input int flen);
    return (f != 2'b11) && !(f == 2'b10 && !en_h) && !(f == 2'b01 && flen == 32);
  endfunction

  // Issue one request on instance A with ready held at 1, then observe its completion.
  task automatic run_a(input logic [1:0] f, input logic [63:0] op, input logic [4:0] d,
                       output logic started, output logic busy1, output int lat,
                       output logic [31:0] res, output logic [4:0] dst);
    @(negedge clk);
    valid = 1'b1; use_unit = 1'b1; fmt = f; operand = op; dest = d; ready = 1'b1;
    #1 started = ostart;
    lat = 0; res = 'x; dst = 'x; busy1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        valid = 1'b0; operand = {$urandom, $urandom}; dest = 5'($urandom); fmt = 2'($urandom);
      end
      #1;
      if (c == 1) busy1 = busy;
      if (ovalid) begin
        lat = c; res = result; dst = odest;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b1; use_unit = 1'b1; fmt = 2'b00; operand = 64'hFFFFFFFF_3F800000;
    dest = 5'd9; flush = 1'b0; ready = 1'b1;
    b_valid = 1'b0; b_use = 1'b1; b_fmt = 2'b00; b_operand = '0; b_dest = '0;
    b_flush = 1'b0; b_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ostart !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", ostart); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ovalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (odest !== 5'h0) begin errors++; $display("FAIL reset_dest got %h want 0", odest); end
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
  endtask

  task automatic test_vectors;
    logic [1:0]  fv [6];
    logic [63:0] ov [6];
    logic st, b1; int lat; logic [31:0] res; logic [4:0] dst; logic [31:0] exp_r;
    fv[0] = 2'b00; ov[0] = 64'hFFFFFFFF_7F800000;
    fv[1] = 2'b00; ov[1] = 64'h00000000_3F800000;
    fv[2] = 2'b01; ov[2] = 64'h00000000_3F800000;
    fv[3] = 2'b10; ov[3] = 64'hFFFF_FFFF_FFFF_8001;
    fv[4] = 2'b10; ov[4] = 64'hFFFF_FFFF_FFFF_7C01;
    fv[5] = 2'b10; ov[5] = 64'h7FFF_FFFF_FFFF_3C00;
    for (int i = 0; i < 6; i++) begin
      run_a(fv[i], ov[i], 5'(i + 1), st, b1, lat, res, dst);
      exp_r = ref_class(fv[i], ov[i], 64);
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL vec%0d_start got %b want 1", i, st); end
      checks++; if (lat != 2) begin errors++; $display("FAIL vec%0d_latency got %0d want 2", i, lat); end
      checks++; if (res !== exp_r) begin errors++; $display("FAIL vec%0d_result got %h want %h", i, res, exp_r); end
      checks++; if (dst !== 5'(i + 1)) begin errors++; $display("FAIL vec%0d_dest got %0d want %0d", i, dst, i + 1); end
    end
    run_a(2'b11, 64'h0, 5'd4, st, b1, lat, res, dst);
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL fmt11_start got %b want 0", st); end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL fmt11_busy got %b want 0", b1); end
    checks++; if (lat != 0) begin errors++; $display("FAIL fmt11_valid got latency %0d want none", lat); end
  endtask

  task automatic test_random;
    logic st, b1; int lat; logic [31:0] res; logic [4:0] dst; logic [31:0] exp_r;
    logic [1:0] f; logic [63:0] op, low, lowmask, raw, e, m, emax; int eb, mb, w; logic [4:0] d;
    for (int n = 0; n < 80; n++) begin
      f  = 2'($urandom_range(0, 3));
      eb = exp_bits(f); mb = man_bits(f); w = 1 + eb + mb;
      emax = (64'd1 << eb) - 1;
      case ($urandom_range(0, 3))
        0: e = 0;
        1: e = emax;
        default: e = {$urandom, $urandom} & emax;
      endcase
      case ($urandom_range(0, 3))
        0: m = 0;
        1: m = 64'd1 << (mb - 1);
        default: m = {$urandom, $urandom} & ((64'd1 << mb) - 1);
      endcase
      low = (64'($urandom_range(0, 1)) << (w - 1)) | (e << mb) | m;
      lowmask = (w == 64) ? ~64'd0 : ((64'd1 << w) - 1);
      raw = ($urandom_range(0, 7) != 0) ? ~64'd0 : {$urandom, $urandom};
      op  = (raw & ~lowmask) | low;
      d   = 5'($urandom);
      run_a(f, op, d, st, b1, lat, res, dst);
      if (fmt_ok_ref(f, 1'b1, 64)) begin
        exp_r = ref_class(f, op, 64);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL rnd%0d_start got %b want 1", n, st); end
        checks++; if (lat != 2) begin errors++; $display("FAIL rnd%0d_latency got %0d want 2", n, lat); end
        checks++; if (res !== exp_r) begin errors++; $display("FAIL rnd%0d_result op %h fmt %0d got %h want %h", n, op, f, res, exp_r); end
        checks++; if (dst !== d) begin errors++; $display("FAIL rnd%0d_dest got %0d want %0d", n, dst, d); end
      end else begin
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL rnd%0d_nostart got %b want 0", n, st); end
        checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle got busy %b want 0", n, b1); end
      end
    end
  endtask

  task automatic test_hold_back_to_back;
    logic [31:0] res0; logic [4:0] dst0; logic [31:0] exp0, exp1; int lat;
    logic [63:0] op1;
    exp0 = ref_class(2'b10, 64'hFFFF_FFFF_FFFF_7C01, 64);
    op1  = 64'hFFFFFFFF_3F800000;
    exp1 = ref_class(2'b00, op1, 64);
    @(negedge clk);
    valid = 1'b1; use_unit = 1'b1; fmt = 2'b10; operand = 64'hFFFF_FFFF_FFFF_7C01;
    dest = 5'd7; ready = 1'b0;
    #1;
    checks++; if (ostart !== 1'b1) begin errors++; $display("FAIL hold_start got %b want 1", ostart); end
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) valid = 1'b0;
      #1;
      if (ovalid) begin lat = c; break; end
    end
    res0 = result; dst0 = odest;
    checks++; if (lat != 2) begin errors++; $display("FAIL hold_latency got %0d want 2", lat); end
    checks++; if (res0 !== exp0) begin errors++; $display("FAIL hold_result got %h want %h", res0, exp0); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({ovalid, result, odest} !== {1'b1, exp0, 5'd7}) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got v=%b r=%h d=%0d want v=1 r=%h d=7",
                 c, ovalid, result, odest, exp0);
      end
    end
    @(negedge clk);
    ready = 1'b1; valid = 1'b1; fmt = 2'b00; operand = op1; dest = 5'd12;
    #1;
    checks++; if (ostart !== 1'b1) begin errors++; $display("FAIL b2b_start got %b want 1", ostart); end
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) valid = 1'b0;
      #1;
      if (c == 1) begin
        checks++;
        if ({ovalid, result} !== {1'b0, exp0}) begin
          errors++; $display("FAIL b2b_gap got v=%b r=%h want v=0 r=%h", ovalid, result, exp0);
        end
      end
      if (ovalid) begin lat = c; break; end
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", lat); end
    checks++; if (result !== exp1) begin errors++; $display("FAIL b2b_result got %h want %h", result, exp1); end
    checks++; if (odest !== 5'd12) begin errors++; $display("FAIL b2b_dest got %0d want 12", odest); end
    @(negedge clk);
  endtask

  task automatic test_flush;
    logic [31:0] prev; int seen; int lat;
    prev = result;
    @(negedge clk);
    valid = 1'b1; use_unit = 1'b1; fmt = 2'b00; operand = 64'hFFFFFFFF_FF800000; dest = 5'd3;
    ready = 1'b1;
    @(negedge clk);
    flush = 1'b1; valid = 1'b1; operand = 64'hFFFFFFFF_00000001; dest = 5'd4;
    #1;
    checks++; if (ostart !== 1'b0) begin errors++; $display("FAIL flush_run_start got %b want 0", ostart); end
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_run_busy got %b want 0", busy); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (ovalid) seen++;
      @(negedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_run_valid got %0d valid cycles want 0", seen); end
    checks++; if (result !== prev) begin errors++; $display("FAIL flush_run_held got %h want %h", result, prev); end

    // Flush arriving in DONE together with ready and a new request.
    @(negedge clk);
    valid = 1'b1; fmt = 2'b01; operand = 64'h8000000000000000; dest = 5'd21; ready = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) valid = 1'b0;
      #1;
      if (ovalid) begin lat = c; break; end
    end
    prev = ref_class(2'b01, 64'h8000000000000000, 64);
    checks++; if (result !== prev) begin errors++; $display("FAIL flush_done_pre got %h want %h", result, prev); end
    @(negedge clk);
    flush = 1'b1; ready = 1'b1; valid = 1'b1; fmt = 2'b00; operand = 64'hFFFFFFFF_3F800000;
    #1;
    checks++; if (ostart !== 1'b0) begin errors++; $display("FAIL flush_done_start got %b want 0", ostart); end
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    #1;
    checks++;
    if ({busy, ovalid, result} !== {1'b0, 1'b0, prev}) begin
      errors++; $display("FAIL flush_done_idle got b=%b v=%b r=%h want b=0 v=0 r=%h", busy, ovalid, result, prev);
    end
  endtask

  task automatic test_reset_mid;
    logic st, b1; int lat; logic [31:0] res; logic [4:0] dst; logic [31:0] exp_r;
    @(negedge clk);
    valid = 1'b1; use_unit = 1'b1; fmt = 2'b10; operand = 64'hFFFF_FFFF_FFFF_FC00;
    dest = 5'd30; ready = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) valid = 1'b0;
      #1;
      if (ovalid) begin lat = c; break; end
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL rstmid_reach_done got %0d want 2", lat); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({ovalid, busy, odest, result} !== {1'b0, 1'b0, 5'd0, 32'd0}) begin
      errors++; $display("FAIL rstmid_clear got v=%b b=%b d=%0d r=%h want all zero", ovalid, busy, odest, result);
    end
    rst = 1'b0;
    run_a(2'b00, 64'hFFFFFFFF_80000000, 5'd2, st, b1, lat, res, dst);
    exp_r = ref_class(2'b00, 64'hFFFFFFFF_80000000, 64);
    checks++; if (res !== exp_r) begin errors++; $display("FAIL rstmid_recover got %h want %h", res, exp_r); end
  endtask

  // Instance B: FLEN=32, no H, LATENCY=1. Only S requests may start.
  task automatic test_narrow_config;
    logic [1:0] f; logic [31:0] op; logic st; int lat; logic [31:0] exp_r;
    for (int n = 0; n < 24; n++) begin
      f  = (n < 3) ? 2'(n + 1) : 2'($urandom_range(0, 3));
      op = (n == 3) ? 32'h3F800000 : $urandom;
      if (n == 4) begin f = 2'b00; op = 32'hFF800000; end
      @(negedge clk);
      b_valid = 1'b1; b_use = 1'b1; b_fmt = f; b_operand = op; b_dest = 5'(n); b_ready = 1'b1;
      #1 st = b_ostart;
      lat = 0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (c == 1) b_valid = 1'b0;
        #1;
        if (c == 1 && !fmt_ok_ref(f, 1'b0, 32)) begin
          checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL narrow%0d_busy got %b want 0", n, b_busy); end
        end
        if (b_ovalid) begin lat = c; break; end
      end
      if (fmt_ok_ref(f, 1'b0, 32)) begin
        exp_r = ref_class(f, {32'h0, op}, 32);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL narrow%0d_start got %b want 1", n, st); end
        checks++; if (lat != 1) begin errors++; $display("FAIL narrow%0d_latency got %0d want 1", n, lat); end
        checks++; if (b_result !== exp_r) begin errors++; $display("FAIL narrow%0d_result got %h want %h", n, b_result, exp_r); end
        checks++; if (b_odest !== 5'(n)) begin errors++; $display("FAIL narrow%0d_dest got %0d want %0d", n, b_odest, n); end
      end else begin
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL narrow%0d_nostart got %b want 0", n, st); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_hold_back_to_back();
    test_flush();
    test_reset_mid();
    test_narrow_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule
